pps_div_regbank: RTL and testbench

Parametrised, multi-channel register bank for the PPS dividers. Each channel has a bus-writable shadow copy and an active copy. The active copy drives its divider and is loaded from the shadow only on an explicit commit, so a multi-byte phase/width change never reaches a divider half-written. The bank sits between the host byte bus (address/data/write strobe) and N_CH PPS divider instances in the clockmaster top level, and replaces the per-divider register blocks.

---
 rtl/pps_div_regbank_pkg.sv | 25 ++
 rtl/pps_div_channel_regs.sv | 78 +++++++
 rtl/pps_div_regbank.sv | 85 ++++++++
 tb/tb_pps_div_regbank.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pps_div_regbank_pkg.sv
// pps_div_regbank_pkg: address map constants and helpers shared by the PPS divider register banks
package pps_div_regbank_pkg;
    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 8;
    localparam int CH_STRIDE = 16;
    localparam logic [3:0] OFF_PER_TRUE = 4'h0;
    localparam logic [3:0] OFF_DIV_NUM = 4'h1;
    localparam logic [3:0] OFF_PHASE = 4'h2;
    localparam logic [3:0] OFF_WIDTH = 4'h6;
    localparam logic [3:0] OFF_START = 4'h7;
    localparam logic [3:0] OFF_STOP = 4'h8;
    localparam logic [3:0] OFF_CTRL = 4'hE;
    localparam logic [3:0] OFF_STATUS = 4'hF;
    localparam int CTRL_COMMIT = 0;
    localparam int CTRL_ABORT = 1;
    localparam int CTRL_CLR_OVR = 2;
    localparam int CTRL_COMMIT_ALL = 7;
    localparam logic [ADDR_WIDTH-1:0] PPS_DIV_BANK0_BASE = 8'h00;
    localparam logic [ADDR_WIDTH-1:0] PPS_DIV_BANK1_BASE = 8'h80;

    // Channel registers are packed per, div, phase bytes, width, start, stop; maps packed byte b to its bus offset.
    function automatic logic [3:0] byte_off(input int b, input int pb);
        return 4'(b < 2 + pb ? b : b - pb + 4);
    endfunction
endpackage

// File: rtl/pps_div_channel_regs.sv
// pps_div_channel_regs: one channel's shadow/active registers, commit tracking and read mux (PPS_DIV_SYNC_COMMIT_EN selects PPS-aligned commits)
module pps_div_channel_regs
    import pps_div_regbank_pkg::*;
#(
    parameter int PHASE_BYTES = 3
) (
    input  logic                              i_clk_10,
    input  logic                              i_rst,
    input  logic                              i_sel,
    input  logic [3:0]                        i_off,
    input  logic [DATA_WIDTH-1:0]             i_data,
    input  logic                              i_wr,
    input  logic                              i_pps_rise,
    input  logic                              i_commit_all,
    output logic [DATA_WIDTH-1:0]             o_rdata,
    output logic [DATA_WIDTH-1:0]             o_per_true,
    output logic [DATA_WIDTH-1:0]             o_div_num,
    output logic [PHASE_BYTES*DATA_WIDTH-1:0] o_phase,
    output logic [DATA_WIDTH-1:0]             o_width,
    output logic [DATA_WIDTH-1:0]             o_start,
    output logic [DATA_WIDTH-1:0]             o_stop,
    output logic                              o_pending,
    output logic                              o_update
);
`ifdef PPS_DIV_SYNC_COMMIT_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif
    localparam int DW = DATA_WIDTH;
    localparam int NB = PHASE_BYTES + 5;

    logic [NB*DW-1:0] r_shadow, r_active;
    logic r_pending, r_overrun, r_update;
    logic w_ctrl, w_set, w_clr, w_apply;
    logic [DW-1:0] w_rdata;

    assign w_ctrl = i_sel & i_wr & (i_off == OFF_CTRL);
    assign w_set = (w_ctrl & i_data[CTRL_COMMIT]) | i_commit_all;
    assign w_clr = w_ctrl & i_data[CTRL_ABORT];
    assign w_apply = SYNC ? (i_pps_rise & r_pending) : w_set;

    // Shadow takes bus writes; active loads the pre-write shadow when a commit applies.
    always_ff @(posedge i_clk_10) begin
        if (i_rst) begin
            r_shadow <= '0;
            r_active <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
            r_update <= 1'b0;
        end else begin
            for (int b = 0; b < NB; b++)
                if (i_sel && i_wr && i_off == byte_off(b, PHASE_BYTES)) r_shadow[b*DW +: DW] <= i_data;
            if (w_apply) r_active <= r_shadow;
            r_update <= w_apply;
            r_pending <= SYNC & ~w_clr & (w_set | (r_pending & ~w_apply));
            r_overrun <= SYNC & ((r_overrun & ~(w_ctrl & i_data[CTRL_CLR_OVR])) | (w_set & ~w_clr & r_pending));
        end
    end

    // Read mux: shadow bytes, status, everything else reads zero.
    always_comb begin
        w_rdata = '0;
        for (int b = 0; b < NB; b++)
            if (i_off == byte_off(b, PHASE_BYTES)) w_rdata = r_shadow[b*DW +: DW];
        if (i_off == OFF_STATUS) w_rdata = {{(DW-2){1'b0}}, r_overrun, r_pending};
    end

    assign o_rdata = i_sel ? w_rdata : '0;
    assign o_per_true = r_active[0 +: DW];
    assign o_div_num = r_active[DW +: DW];
    assign o_phase = r_active[2*DW +: PHASE_BYTES*DW];
    assign o_width = r_active[(2+PHASE_BYTES)*DW +: DW];
    assign o_start = r_active[(3+PHASE_BYTES)*DW +: DW];
    assign o_stop = r_active[(4+PHASE_BYTES)*DW +: DW];
    assign o_pending = r_pending;
    assign o_update = r_update;
endmodule

// File: rtl/pps_div_regbank.sv
// pps_div_regbank: host byte-bus register bank with shadow/active copies for N_CH PPS dividers (PPS_DIV_SYNC_COMMIT_EN aligns commits to i_pps)
module pps_div_regbank
    import pps_div_regbank_pkg::*;
#(
    parameter int                    N_CH        = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 'h00,
    parameter int                    PHASE_BYTES = 3
) (
    input  logic                                   i_clk_10,
    input  logic                                   i_rst,
    input  logic [ADDR_WIDTH-1:0]                  i_addr,
    input  logic [DATA_WIDTH-1:0]                  i_data,
    input  logic                                   i_wr,
    input  logic                                   i_pps,
    output logic [DATA_WIDTH-1:0]                  o_data,
    output logic                                   o_hit,
    output logic [N_CH*DATA_WIDTH-1:0]             o_periodic_true,
    output logic [N_CH*DATA_WIDTH-1:0]             o_div_number,
    output logic [N_CH*PHASE_BYTES*DATA_WIDTH-1:0] o_phase_us,
    output logic [N_CH*DATA_WIDTH-1:0]             o_width_us,
    output logic [N_CH*DATA_WIDTH-1:0]             o_start,
    output logic [N_CH*DATA_WIDTH-1:0]             o_stop,
    output logic [N_CH-1:0]                        o_pending,
    output logic [N_CH-1:0]                        o_update
);
    localparam int DW = DATA_WIDTH;
    localparam int PW = PHASE_BYTES * DATA_WIDTH;

    logic [ADDR_WIDTH:0] w_diff;
    logic [ADDR_WIDTH-1:0] w_rel;
    logic w_in_bank, w_pps_rise, w_commit_all;
    logic [N_CH-1:0] w_sel;
    logic [DW-1:0] w_rd [N_CH];
    logic [DW-1:0] w_rd_or;
    logic r_pps_d;

    // The borrow bit of the subtraction flags addresses below the bank.
    assign w_diff = {1'b0, i_addr} - {1'b0, BASE_ADDR};
    assign w_rel = w_diff[ADDR_WIDTH-1:0];
    assign w_in_bank = ~w_diff[ADDR_WIDTH] & (32'(w_rel[ADDR_WIDTH-1:4]) < N_CH);
    assign w_pps_rise = i_pps & ~r_pps_d;
    assign w_commit_all = w_in_bank & i_wr & (w_rel[3:0] == OFF_CTRL) & i_data[CTRL_COMMIT_ALL];

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign w_sel[c] = w_in_bank & (32'(w_rel[ADDR_WIDTH-1:4]) == c);
        pps_div_channel_regs #(.PHASE_BYTES(PHASE_BYTES)) u_regs (
            .i_clk_10     (i_clk_10),
            .i_rst        (i_rst),
            .i_sel        (w_sel[c]),
            .i_off        (w_rel[3:0]),
            .i_data       (i_data),
            .i_wr         (i_wr),
            .i_pps_rise   (w_pps_rise),
            .i_commit_all (w_commit_all),
            .o_rdata      (w_rd[c]),
            .o_per_true   (o_periodic_true[c*DW +: DW]),
            .o_div_num    (o_div_number[c*DW +: DW]),
            .o_phase      (o_phase_us[c*PW +: PW]),
            .o_width      (o_width_us[c*DW +: DW]),
            .o_start      (o_start[c*DW +: DW]),
            .o_stop       (o_stop[c*DW +: DW]),
            .o_pending    (o_pending[c]),
            .o_update     (o_update[c])
        );
    end

    // Unselected channels drive zero, so the read data is a plain OR.
    always_comb begin
        w_rd_or = '0;
        for (int c = 0; c < N_CH; c++) w_rd_or = w_rd_or | w_rd[c];
    end

    // Registered read port and the PPS edge detector.
    always_ff @(posedge i_clk_10) begin
        if (i_rst) begin
            r_pps_d <= 1'b0;
            o_data <= '0;
            o_hit <= 1'b0;
        end else begin
            r_pps_d <= i_pps;
            o_data <= i_wr ? o_data : w_rd_or;
            o_hit <= ~i_wr & w_in_bank;
        end
    end
endmodule

// File: tb/tb_pps_div_regbank.sv
// tb_pps_div_regbank: scoreboard bench for the PPS divider register bank
module tb_pps_div_regbank;
    localparam int N_CH = 4;
    localparam int PB = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr = 1'b0;
    logic pps = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] data = 8'h00;
    logic [7:0] o_data;
    logic o_hit;
    logic [N_CH*8-1:0] per, div, width, start, stop;
    logic [N_CH*PB*8-1:0] phase;
    logic [N_CH-1:0] pend, upd;

    int checks = 0;
    int errors = 0;
    logic [8:0] rd_q[$];
    logic [3:0] upd_q[$];
    logic rd_en = 1'b0;
    logic rd_pend = 1'b0;
    logic [8:0] e_rd;
    logic [3:0] e_up;

    always #50 clk = ~clk;

    pps_div_regbank #(.N_CH(N_CH), .BASE_ADDR(8'h00), .PHASE_BYTES(PB)) dut (
        .i_clk_10        (clk),
        .i_rst           (rst),
        .i_addr          (addr),
        .i_data          (data),
        .i_wr            (wr),
        .i_pps           (pps),
        .o_data          (o_data),
        .o_hit           (o_hit),
        .o_periodic_true (per),
        .o_div_number    (div),
        .o_phase_us      (phase),
        .o_width_us      (width),
        .o_start         (start),
        .o_stop          (stop),
        .o_pending       (pend),
        .o_update        (upd)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) rd_pend <= rd_en;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
                e_rd = rd_q.pop_front();
                chk("rd_data", o_data, e_rd[7:0]);
                chk("rd_hit", o_hit, e_rd[8]);
            end
        end
        if (upd != 0) begin
            if (upd_q.size() == 0) chk("update_unexpected", upd, 0);
            else begin
                e_up = upd_q.pop_front();
                chk("update", upd, e_up);
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wrb(input logic [7:0] a, input logic [7:0] d);
        addr = a;
        data = d;
        wr = 1'b1;
        cyc();
        wr = 1'b0;
    endtask

    task automatic rdb(input logic [7:0] a, input logic [7:0] d, input logic h);
        addr = a;
        rd_en = 1'b1;
        rd_q.push_back({h, d});
        cyc();
        rd_en = 1'b0;
    endtask

    task automatic pulse();
        pps = 1'b1;
        cyc();
        pps = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        cyc(3);
        rst = 1'b0;
        chk("rst_update", upd, 0);
        chk("rst_pending", pend, 0);
        chk("rst_phase", phase, 0);
        chk("rst_div", div, 0);
        chk("rst_data", o_data, 0);
        chk("rst_hit", o_hit, 0);
        for (int c = 0; c < 4; c++)
            for (int o = 0; o < 16; o++) rdb(8'(c * 16 + o), 8'h00, 1'b1);
        wrb(8'h12, 8'h12);
        wrb(8'h13, 8'h34);
        wrb(8'h14, 8'h56);
        wrb(8'h15, 8'hAA);
        wrb(8'h19, 8'hFF);
        pulse();
        cyc();
        chk("phase_no_commit", phase[24 +: 24], 0);
        rdb(8'h12, 8'h12, 1'b1);
        rdb(8'h13, 8'h34, 1'b1);
        rdb(8'h14, 8'h56, 1'b1);
        rdb(8'h15, 8'h00, 1'b1);
        rdb(8'h19, 8'h00, 1'b1);
        rdb(8'h1E, 8'h00, 1'b1);
`ifdef PPS_DIV_SYNC_COMMIT_EN
        wrb(8'h1E, 8'h01);
        cyc(5);
        chk("phase_wait_pps", phase[24 +: 24], 0);
        chk("pending_ch1", pend, 4'b0010);
        upd_q.push_back(4'b0010);
        pps = 1'b1;
        cyc();
        pps = 1'b0;
        chk("phase_commit", phase[24 +: 24], 24'h563412);
        chk("pending_cleared", pend, 0);
        rdb(8'h1F, 8'h00, 1'b1);
        wrb(8'h1E, 8'h01);
        upd_q.push_back(4'b0010);
        pps = 1'b1;
        cyc(3);
        pps = 1'b0;
        cyc(2);
        chk("pending_after_hold", pend, 0);
        wrb(8'h2E, 8'h01);
        wrb(8'h2E, 8'h01);
        rdb(8'h2F, 8'h03, 1'b1);
        wrb(8'h2E, 8'h04);
        rdb(8'h2F, 8'h01, 1'b1);
        wrb(8'h2E, 8'h02);
        rdb(8'h2F, 8'h00, 1'b1);
        wrb(8'h2E, 8'h03);
        rdb(8'h2F, 8'h00, 1'b1);
        chk("pending_after_abort", pend, 0);
        wrb(8'h01, 8'h05);
        wrb(8'h0E, 8'h01);
        upd_q.push_back(4'b0001);
        pps = 1'b1;
        wrb(8'h01, 8'h0A);
        pps = 1'b0;
        chk("div_old_shadow", div[7:0], 8'h05);
        rdb(8'h01, 8'h0A, 1'b1);
        cyc();
        pps = 1'b1;
        wrb(8'h0E, 8'h01);
        pps = 1'b0;
        cyc();
        chk("commit_with_pps_pending", pend, 4'b0001);
        chk("commit_with_pps_div", div[7:0], 8'h05);
        upd_q.push_back(4'b0001);
        pulse();
        chk("div_next_pps", div[7:0], 8'h0A);
        chk("pending_next_pps", pend, 0);
        cyc();
`else
        upd_q.push_back(4'b0010);
        wrb(8'h1E, 8'h01);
        chk("phase_commit", phase[24 +: 24], 24'h563412);
        chk("pending_stays_0", pend, 0);
        cyc(5);
        pulse();
        rdb(8'h1F, 8'h00, 1'b1);
        pps = 1'b1;
        cyc(3);
        pps = 1'b0;
        upd_q.push_back(4'b0100);
        upd_q.push_back(4'b0100);
        wrb(8'h2E, 8'h01);
        wrb(8'h2E, 8'h01);
        rdb(8'h2F, 8'h00, 1'b1);
        wrb(8'h2E, 8'h02);
        rdb(8'h2F, 8'h00, 1'b1);
        upd_q.push_back(4'b0100);
        wrb(8'h2E, 8'h03);
        rdb(8'h2F, 8'h00, 1'b1);
        wrb(8'h01, 8'h05);
        upd_q.push_back(4'b0001);
        wrb(8'h0E, 8'h01);
        chk("div_commit", div[7:0], 8'h05);
        pps = 1'b1;
        wrb(8'h01, 8'h0A);
        pps = 1'b0;
        chk("div_old_shadow", div[7:0], 8'h05);
        rdb(8'h01, 8'h0A, 1'b1);
        upd_q.push_back(4'b0001);
        wrb(8'h0E, 8'h01);
        chk("div_second_commit", div[7:0], 8'h0A);
        chk("pending_stays_0b", pend, 0);
`endif
        rdb(8'h40, 8'h00, 1'b0);
        rdb(8'hFF, 8'h00, 1'b0);
`ifdef PPS_DIV_SYNC_COMMIT_EN
        wrb(8'h3E, 8'h80);
        chk("pending_all", pend, 4'b1111);
        upd_q.push_back(4'b1111);
        pulse();
`else
        upd_q.push_back(4'b1111);
        wrb(8'h3E, 8'h80);
`endif
        cyc();
        chk("pending_after_all", pend, 0);
        chk("phase_after_all", phase[24 +: 24], 24'h563412);
        rdb(8'h12, 8'h12, 1'b1);
        wrb(8'h08, 8'h77);
        chk("wr_keeps_data", o_data, 8'h12);
        chk("wr_clears_hit", o_hit, 0);
        rdb(8'h08, 8'h77, 1'b1);
`ifdef PPS_DIV_SYNC_COMMIT_EN
        wrb(8'h1E, 8'h01);
        chk("pending_before_rst", pend, 4'b0010);
`else
        upd_q.push_back(4'b0010);
        wrb(8'h1E, 8'h01);
`endif
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_mid_pending", pend, 0);
        chk("rst_mid_phase", phase, 0);
        chk("rst_mid_data", o_data, 0);
        pulse();
        cyc(3);
        rdb(8'h12, 8'h00, 1'b1);
        cyc(3);
        chk("rd_q_drained", rd_q.size(), 0);
        chk("upd_q_drained", upd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
